// File: rtl/switch_pkg.sv
// Types shared by the Switch, MatCore and the per-core send queue.
// A switch vector is a fixed number of IEEE-754 single-precision lanes.
package switch_pkg;

  localparam int unsigned LANE_W         = 32;
  localparam int unsigned SWITCH_WIDTH   = 16;
  localparam int unsigned SWITCH_CORES   = 2;
  localparam int unsigned CORE_IDX_W     = $clog2(SWITCH_CORES);

  typedef logic [LANE_W-1:0]               lane_t;
  typedef lane_t [SWITCH_WIDTH-1:0]        switch_vec_t;
  typedef logic [CORE_IDX_W-1:0]           core_idx_t;

endpackage

// File: rtl/switch_send_queue_if.sv
// Core-side enqueue port plus Switch-side send port of one send queue.
// The queue uses the slave modport; whatever drives it uses master.
interface switch_send_queue_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CORE_SIZE = 2,
  parameter int unsigned DEPTH     = 4
);
  import switch_pkg::*;

  localparam int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE);
  localparam int unsigned COUNT_W        = $clog2(DEPTH) + 1;

  logic                              enq_valid;
  logic [CORE_ADDR_SIZE-1:0]         enq_core_idx;
  logic [WIDTH-1:0][LANE_W-1:0]      enq_data;
  logic                              enq_ready;
  logic                              send_ready;
  logic [CORE_ADDR_SIZE-1:0]         send_core_idx;
  logic [WIDTH-1:0][LANE_W-1:0]      send_data;
  logic                              send_ok;
  logic [COUNT_W-1:0]                count;
  logic [15:0]                       sent_total;
  logic                              err_ok_empty;

  modport slave (
    input  enq_valid, enq_core_idx, enq_data, send_ok,
    output enq_ready, send_ready, send_core_idx, send_data, count, sent_total, err_ok_empty
  );

  modport master (
    output enq_valid, enq_core_idx, enq_data, send_ok,
    input  enq_ready, send_ready, send_core_idx, send_data, count, sent_total, err_ok_empty
  );

endinterface

// File: rtl/switch_queue_ctrl.sv
// Pointer, occupancy and status bookkeeping for the send queue.
// Storage lives in the parent; this block only says where and when to write/read.
module switch_queue_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned COUNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enq_valid,
  input  logic               send_ok,
  output logic               enq_ready,
  output logic               send_ready,
  output logic               enq_fire,
  output logic [PTR_W-1:0]   wr_ptr,
  output logic [PTR_W-1:0]   rd_ptr,
  output logic [COUNT_W-1:0] count,
  output logic [15:0]        sent_total,
  output logic               err_ok_empty
);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [15:0]        sent_q, sent_d;
  logic               err_q, err_d;
  logic               deq_fire;

  // enq_ready looks only at occupancy: a pop in the same cycle never frees a slot early.
  assign enq_ready  = (count_q != COUNT_W'(DEPTH));
  assign send_ready = (count_q != '0);
  assign enq_fire   = enq_valid && enq_ready && !reset;
  assign deq_fire   = send_ok && send_ready && !reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sent_d   = sent_q;
    err_d    = err_q;

    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase

    if (deq_fire && (sent_q != 16'hFFFF)) sent_d = sent_q + 16'd1;
    if (send_ok && !send_ready) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      err_q    <= err_d;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign sent_total   = sent_q;
  assign err_ok_empty = err_q;

endmodule

// File: rtl/switch_send_queue.sv
// Per-core FIFO between MatCore send outputs and the Switch send inputs.
// Head entry is presented combinationally; payload lanes are stored untouched.
module switch_send_queue
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CORE_SIZE = 2,
  parameter int unsigned DEPTH     = 4
) (
  input  logic               clock,
  input  logic               reset,
  switch_send_queue_if.slave bus
);

  localparam int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE);
  localparam int unsigned PTR_W          = $clog2(DEPTH);
  localparam int unsigned COUNT_W        = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CORE_ADDR_SIZE-1:0]    core_idx;
    logic [WIDTH-1:0][LANE_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               enq_fire;
  logic               enq_ready;
  logic               send_ready;
  logic [COUNT_W-1:0] count;
  logic [15:0]        sent_total;
  logic               err_ok_empty;

  switch_queue_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .enq_valid    (bus.enq_valid),
    .send_ok      (bus.send_ok),
    .enq_ready    (enq_ready),
    .send_ready   (send_ready),
    .enq_fire     (enq_fire),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .sent_total   (sent_total),
    .err_ok_empty (err_ok_empty)
  );

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      mem[wr_ptr] <= '{core_idx: bus.enq_core_idx, data: bus.enq_data};
    end
  end

  assign bus.enq_ready     = enq_ready;
  assign bus.send_ready    = send_ready;
  assign bus.send_core_idx = mem[rd_ptr].core_idx;
  assign bus.send_data     = mem[rd_ptr].data;
  assign bus.count         = count;
  assign bus.sent_total    = sent_total;
  assign bus.err_ok_empty  = err_ok_empty;

endmodule

// File: tb/tb_switch_send_queue.sv
// Directed bench for switch_send_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_switch_send_queue;
  import switch_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned C  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned CA = $clog2(C);

  // 1.0 .. 8.0 as IEEE-754 single
  localparam logic [31:0] FLT [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                      32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  localparam logic [31:0] F1P5 = 32'h3FC00000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  switch_send_queue_if #(.WIDTH(W), .CORE_SIZE(C), .DEPTH(D)) bus ();

  switch_send_queue #(.WIDTH(W), .CORE_SIZE(C), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [CA-1:0]          idx;
    logic [W-1:0][31:0]     data;
  } ent_t;

  ent_t        m_q[$];
  int unsigned m_sent;
  logic        m_err;
  bit          started;
  logic [31:0] rx[$];
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO updated with the inputs seen at each rising edge.
  always @(posedge clock) begin
    bit enq;
    bit deq;
    if (reset) begin
      m_q.delete();
      rx.delete();
      m_sent  = 0;
      m_err   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      enq = bus.enq_valid && (m_q.size() < D);
      deq = bus.send_ok && (m_q.size() > 0);
      if (bus.send_ok && m_q.size() == 0) m_err = 1'b1;
      if (deq) begin
        rx.push_back(bus.send_data[0]);
        void'(m_q.pop_front());
        if (m_sent < 32'hFFFF) m_sent++;
      end
      if (enq) m_q.push_back('{idx: bus.enq_core_idx, data: bus.enq_data});
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("enq_ready", 32'(bus.enq_ready), 32'(m_q.size() < D));
      chk("send_ready", 32'(bus.send_ready), 32'(m_q.size() > 0));
      chk("count", 32'(bus.count), 32'(m_q.size()));
      chk("sent_total", 32'(bus.sent_total), m_sent);
      chk("err_ok_empty", 32'(bus.err_ok_empty), 32'(m_err));
      if (m_q.size() > 0) begin
        chk("send_core_idx", 32'(bus.send_core_idx), 32'(m_q[0].idx));
        checks++;
        if (bus.send_data !== m_q[0].data) begin
          failures++;
          $display("FAIL send_data: got lane0 %0h expected lane0 %0h at %0t",
                   bus.send_data[0], m_q[0].data[0], $time);
        end
      end
    end
  end

  task automatic cyc(input logic ev, input logic [CA-1:0] idx, input logic [31:0] l0,
                     input logic ok);
    bus.enq_valid    = ev;
    bus.enq_core_idx = idx;
    for (int i = 0; i < W; i++) bus.enq_data[i] = l0 ^ (32'(i) << 4);
    bus.send_ok      = ok;
    @(negedge clock);
    #1;
  endtask

  // Enqueue and send_ok are held high during reset; both must be ignored.
  task automatic do_reset(input int n);
    reset         = 1'b1;
    bus.enq_valid = 1'b1;
    bus.send_ok   = 1'b1;
    repeat (n) @(negedge clock);
    #1;
    reset         = 1'b0;
    bus.enq_valid = 1'b0;
    bus.send_ok   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    started  = 1'b0;
    bus.enq_core_idx = '0;
    bus.enq_data     = '0;
    do_reset(2);

    chk("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    chk("rst_send_ready", 32'(bus.send_ready), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_sent_total", 32'(bus.sent_total), 32'd0);
    chk("rst_err", 32'(bus.err_ok_empty), 32'd0);

    // One vector, visible the cycle after enqueue
    cyc(1'b1, 1'b1, F1P5, 1'b0);
    chk("s1_send_ready", 32'(bus.send_ready), 32'd1);
    chk("s1_core_idx", 32'(bus.send_core_idx), 32'd1);
    chk("s1_lane0", bus.send_data[0], F1P5);
    chk("s1_count", 32'(bus.count), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("s1_drained", 32'(bus.count), 32'd0);

    // Fill, hold a fifth offer while full, then pop to let it in
    for (int k = 0; k < 4; k++) cyc(1'b1, CA'(k), FLT[k], 1'b0);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_enq_ready", 32'(bus.enq_ready), 32'd0);
    cyc(1'b1, 1'b1, FLT[4], 1'b0);
    cyc(1'b1, 1'b1, FLT[4], 1'b0);
    chk("held_count", 32'(bus.count), 32'd4);
    cyc(1'b1, 1'b1, FLT[4], 1'b1);
    chk("full_enq_deq_count", 32'(bus.count), 32'd3);
    chk("full_enq_deq_head", bus.send_data[0], FLT[1]);
    cyc(1'b1, 1'b1, FLT[4], 1'b0);
    chk("fifth_accepted", 32'(bus.count), 32'd4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("at_two_head", bus.send_data[0], FLT[3]);
    cyc(1'b1, 1'b0, FLT[6], 1'b1);
    chk("simul_count", 32'(bus.count), 32'd2);
    chk("simul_head", bus.send_data[0], FLT[4]);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("s2_empty", 32'(bus.count), 32'd0);
    chk("s2_sent", 32'(bus.sent_total), 32'd7);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // Six vectors with send_ok every other cycle; pointers wrap
    do_reset(1);
    for (int k = 0; k < 6; k++) cyc(1'b1, CA'(k), FLT[k], k[0]);
    for (int n = 0; n < 8; n++) begin
      if (!bus.send_ready) break;
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("s3_count", 32'(bus.count), 32'd0);
    chk("s3_sent", 32'(bus.sent_total), 32'd6);
    chk("s3_rx_size", 32'(rx.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx.size()) chk("s3_rx_order", rx[i], FLT[i]);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // send_ok on empty queue sets the sticky error
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("err_set", 32'(bus.err_ok_empty), 32'd1);
    chk("err_count", 32'(bus.count), 32'd0);
    chk("err_sent", 32'(bus.sent_total), 32'd6);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, FLT[7], 1'b0);
    chk("err_sticky", 32'(bus.err_ok_empty), 32'd1);

    // Reset with entries in flight
    cyc(1'b1, 1'b1, FLT[0], 1'b0);
    cyc(1'b1, 1'b0, FLT[1], 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    do_reset(1);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_send_ready", 32'(bus.send_ready), 32'd0);
    chk("mid_rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    chk("mid_rst_sent", 32'(bus.sent_total), 32'd0);
    chk("mid_rst_err", 32'(bus.err_ok_empty), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
